// File: rtl/instr_trace_fifo.sv
// rtl/instr_trace_fifo.sv - show-ahead FIFO of committed {pc, instr} pairs with drop accounting
module instr_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             step,
  input  logic [15:0]      pc,
  input  logic [15:0]      instr,
  input  logic             freeze,
  input  logic             ovf_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_pc,
  output logic [15:0]      out_instr,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic [7:0]       drop_cnt
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic capture;
  logic full;
  logic push;
  logic pop;
  logic drop;

  assign full    = (count_q == FULL_CNT);
  assign pop     = (count_q != '0) && out_ready;
  // A full FIFO still takes a new entry when the head leaves on the same edge.
  assign capture = step && !freeze;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    // Set beats acknowledge when both land on the same edge.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_ack) ovf_d = 1'b0;

    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (Clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !Clear) mem_q[wr_ptr_q] <= {pc, instr};
  end

  assign out_valid = (count_q != '0);
  assign out_pc    = mem_q[rd_ptr_q][31:16];
  assign out_instr = mem_q[rd_ptr_q][15:0];
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
